// File: rtl/knight_pkg.sv
// Shared constants and types for the knight sprite path (address gen, ROMs, colour mux).
package knight_pkg;

  localparam int SPRITE_W = 50;
  localparam int SPRITE_H = 64;
  localparam int ADDR_W   = 12;

  typedef enum logic {
    IDLE = 1'b0,
    WALK = 1'b1
  } anim_state_t;

  // Row offset into a 50-wide sprite: v*50 = v*32 + v*16 + v*2, shifts and adds only.
  function automatic logic [ADDR_W-1:0] row_offset(input logic [5:0] v);
    logic [ADDR_W-1:0] w;
    w = {{(ADDR_W-6){1'b0}}, v};
    return (w << 5) + (w << 4) + (w << 1);
  endfunction

endpackage

// File: rtl/knight_anim_fsm.sv
// Walk-animation sequencer for the knight sprite.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  IDLE  | standing pose, frame_sel_int = 0
//  WALK  | cycling walk frames 1..NUM_WALK_FRAMES, each held
//        | FRAMES_PER_STEP video frames
//
// Everything advances only on sof. frame_sel_nxt exposes the value the
// frame select will take after this cycle, so the pixel that carries sof
// can already be addressed with the new frame.
module knight_anim_fsm
  import knight_pkg::*;
#(
  parameter int FRAMES_PER_STEP = 6,
  parameter int NUM_WALK_FRAMES = 4
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       sof,
  input  logic       walking,
  output logic [2:0] frame_sel_int,
  output logic [2:0] frame_sel_nxt
);

  localparam int CW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CW-1:0] STEP_LAST  = CW'(FRAMES_PER_STEP - 1);
  localparam logic [2:0]    FRAME_LAST = 3'(NUM_WALK_FRAMES);

  anim_state_t   state_q, state_d;
  logic [CW-1:0] step_q, step_d;
  logic [2:0]    frame_q, frame_d;

  // State, step counter and frame select registers.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      frame_q <= frame_d;
    end
  end

  // Next-state logic; holds everything outside sof.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    frame_d = frame_q;
    if (sof) begin
      unique case (state_q)
        IDLE: begin
          if (walking) begin
            state_d = WALK;
            frame_d = 3'd1;
            step_d  = '0;
          end
        end
        WALK: begin
          if (!walking) begin
            state_d = IDLE;
            frame_d = 3'd0;
            step_d  = '0;
          end else if (step_q == STEP_LAST) begin
            step_d  = '0;
            frame_d = (frame_q == FRAME_LAST) ? 3'd1 : frame_q + 3'd1;
          end else begin
            step_d  = step_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          frame_d = 3'd0;
          step_d  = '0;
        end
      endcase
    end
  end

  assign frame_sel_int = frame_q;
  assign frame_sel_nxt = frame_d;

endmodule

// File: rtl/knight_sprite_addr_gen.sv
// Knight sprite ROM address generator: per-pixel hit test against the
// frame-latched knight position, mirrored 50x64 address, walk frame select,
// and a two-stage pipeline lining sprite_on up with the palette register.
module knight_sprite_addr_gen
  import knight_pkg::*;
#(
  parameter int FRAMES_PER_STEP = 6,
  parameter int NUM_WALK_FRAMES = 4
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic              facing_left,
  input  logic              walking,
  output logic [ADDR_W-1:0] rom_address,
  output logic [2:0]        frame_sel,
  output logic              sprite_on
);

  logic              at_origin, origin_q, sof;
  logic [9:0]        pos_x_q, pos_y_q;
  logic              facing_q;
  logic [9:0]        pos_x_eff, pos_y_eff;
  logic              facing_eff;
  logic [10:0]       dx, dy;
  logic              hit;
  logic [5:0]        xm;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [2:0]        frame_sel_int, frame_sel_nxt, frame_d, frame_q;
  logic              hit_q, on_q;

  assign at_origin = (DrawX == 10'd0) && (DrawY == 10'd0);
  assign sof       = at_origin && !origin_q;

  // Remember whether the previous pixel was the origin, for sof edge detection.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) origin_q <= 1'b0;
    else          origin_q <= at_origin;
  end

  // Per-frame snapshot of position and facing, so a frame never tears.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      pos_x_q  <= '0;
      pos_y_q  <= '0;
      facing_q <= 1'b0;
    end else if (sof) begin
      pos_x_q  <= pos_x;
      pos_y_q  <= pos_y;
      facing_q <= facing_left;
    end
  end

  // On the sof pixel itself the snapshot is still being written, so use the live inputs.
  assign pos_x_eff  = sof ? pos_x       : pos_x_q;
  assign pos_y_eff  = sof ? pos_y       : pos_y_q;
  assign facing_eff = sof ? facing_left : facing_q;

  knight_anim_fsm #(
    .FRAMES_PER_STEP(FRAMES_PER_STEP),
    .NUM_WALK_FRAMES(NUM_WALK_FRAMES)
  ) u_anim (
    .vga_clk      (vga_clk),
    .reset_n      (reset_n),
    .sof          (sof),
    .walking      (walking),
    .frame_sel_int(frame_sel_int),
    .frame_sel_nxt(frame_sel_nxt)
  );

  assign frame_d = sof ? frame_sel_nxt : frame_sel_int;

  // Hit test on 11-bit two's complement offsets; negative offsets clip at left/top.
  assign dx  = {1'b0, DrawX} - {1'b0, pos_x_eff};
  assign dy  = {1'b0, DrawY} - {1'b0, pos_y_eff};
  assign hit = !dx[10] && (dx < 11'(SPRITE_W)) && !dy[10] && (dy < 11'(SPRITE_H));

  assign xm     = facing_eff ? (6'(SPRITE_W - 1) - dx[5:0]) : dx[5:0];
  assign addr_d = hit ? (row_offset(dy[5:0]) + {{(ADDR_W-6){1'b0}}, xm}) : '0;

  // Stage 1: address, frame select and hit registered together.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      frame_q <= '0;
      hit_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      frame_q <= frame_d;
      hit_q   <= hit;
    end
  end

  // Stage 2: sprite_on one cycle later, matching the palette colour register.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) on_q <= 1'b0;
    else          on_q <= hit_q;
  end

  assign rom_address = addr_q;
  assign frame_sel   = frame_q;
  assign sprite_on   = on_q;

endmodule

// File: tb/tb_knight_sprite_addr_gen.sv
// Directed bench for knight_sprite_addr_gen. Frames are shortened: a frame
// start is produced by one off-origin pixel followed by the origin pixel.
module tb_knight_sprite_addr_gen;

  logic        vga_clk;
  logic        reset_n;
  logic [9:0]  DrawX, DrawY, pos_x, pos_y;
  logic        facing_left, walking;
  logic [11:0] rom_address;
  logic [2:0]  frame_sel;
  logic        sprite_on;

  int n_checks = 0;
  int n_errors = 0;

  knight_sprite_addr_gen #(
    .FRAMES_PER_STEP(6),
    .NUM_WALK_FRAMES(4)
  ) dut (
    .vga_clk    (vga_clk),
    .reset_n    (reset_n),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .facing_left(facing_left),
    .walking    (walking),
    .rom_address(rom_address),
    .frame_sel  (frame_sel),
    .sprite_on  (sprite_on)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one pixel, check the stage-1 address one cycle later, then move the
  // beam away and check sprite_on exactly two cycles after the pixel.
  task automatic probe(input string tag, input int x, input int y,
                       input int exp_addr, input int exp_on);
    @(negedge vga_clk);
    DrawX = 10'(x);
    DrawY = 10'(y);
    @(negedge vga_clk);
    check({tag, ".addr"}, int'(rom_address), exp_addr);
    DrawX = 10'd799;
    DrawY = 10'd524;
    @(negedge vga_clk);
    check({tag, ".on"}, int'(sprite_on), exp_on);
  endtask

  // Off-origin pixel then origin pixel; returns after the sof pixel has registered.
  task automatic new_frame();
    @(negedge vga_clk);
    DrawX = 10'd5;
    DrawY = 10'd5;
    @(negedge vga_clk);
    DrawX = 10'd0;
    DrawY = 10'd0;
    @(negedge vga_clk);
    DrawX = 10'd5;
    DrawY = 10'd5;
  endtask

  initial begin
    reset_n     = 1'b0;
    DrawX       = 10'd5;
    DrawY       = 10'd5;
    pos_x       = 10'd100;
    pos_y       = 10'd200;
    facing_left = 1'b0;
    walking     = 1'b0;
    #1;
    check("rst.addr",  int'(rom_address), 0);
    check("rst.frame", int'(frame_sel), 0);
    check("rst.on",    int'(sprite_on), 0);
    repeat (2) @(negedge vga_clk);
    reset_n = 1'b1;

    // Address corners, facing right.
    new_frame();
    probe("corner.tl",    100, 200, 0,    1);
    probe("corner.br",    149, 263, 3199, 1);
    probe("corner.right", 150, 263, 0,    0);
    probe("corner.left",   99, 200, 0,    0);
    probe("corner.below", 100, 264, 0,    0);
    probe("corner.mid",   110, 210, 510,  1);

    // Mirroring.
    facing_left = 1'b1;
    new_frame();
    probe("mirror.tl",  100, 200, 49, 1);
    probe("mirror.r1",  149, 201, 50, 1);
    probe("mirror.mid", 110, 210, 539, 1);

    // Clipping at the left edge and at the origin.
    pos_x = 10'd780; pos_y = 10'd0; facing_left = 1'b0;
    new_frame();
    probe("clip.neg",  5,   10, 0,   0);
    probe("clip.edge", 799, 10, 519, 1);
    pos_x = 10'd0;
    new_frame();
    probe("clip.origin", 0, 0, 0, 1);

    // Mid-frame changes are ignored until the next sof.
    pos_x = 10'd100; pos_y = 10'd200; facing_left = 1'b0; walking = 1'b0;
    new_frame();
    probe("mid.before", 100, 240, 2000, 1);
    pos_x = 10'd300; facing_left = 1'b1; walking = 1'b1;
    probe("mid.after", 100, 240, 2000, 1);
    check("mid.frame", int'(frame_sel), 0);
    probe("mid.newpos", 300, 240, 0, 0);
    new_frame();
    check("next.frame", int'(frame_sel), 1);
    probe("next.newpos", 300, 240, 2049, 1);
    probe("next.oldpos", 100, 240, 0,    0);

    // Walk cycle: reset to idle first, then 25 walking frames and one idle frame.
    walking = 1'b0;
    new_frame();
    check("walk.idle", int'(frame_sel), 0);
    walking = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      new_frame();
      check($sformatf("walk.f%0d", i), int'(frame_sel), ((i - 1) / 6) % 4 + 1);
      // Toggle walking between sofs; it must be ignored.
      walking = 1'b0;
      @(negedge vga_clk);
      check($sformatf("walk.hold%0d", i), int'(frame_sel), ((i - 1) / 6) % 4 + 1);
      walking = 1'b1;
    end
    walking = 1'b0;
    new_frame();
    check("walk.stop", int'(frame_sel), 0);

    // Reset mid-line while walking and on a hit pixel.
    walking = 1'b1;
    new_frame();
    check("prerst.frame", int'(frame_sel), 1);
    @(negedge vga_clk);
    DrawX = 10'd300; DrawY = 10'd240;
    @(negedge vga_clk);
    @(negedge vga_clk);
    check("prerst.addr", int'(rom_address), 2049);
    check("prerst.on",   int'(sprite_on), 1);
    #2 reset_n = 1'b0;
    #1;
    check("midrst.addr",  int'(rom_address), 0);
    check("midrst.frame", int'(frame_sel), 0);
    check("midrst.on",    int'(sprite_on), 0);
    @(negedge vga_clk);
    reset_n = 1'b1;
    walking = 1'b0;
    for (int i = 0; i < 3; i++) begin
      new_frame();
      check($sformatf("postrst.f%0d", i), int'(frame_sel), 0);
    end
    walking = 1'b1;
    new_frame();
    check("postrst.walk", int'(frame_sel), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/knight_sprite_addr_gen.md
# knight_sprite_addr_gen

Address-generation stage that drives the knight sprite ROMs in the Hollow Knight video path. Each pixel it compares the beam position (DrawX, DrawY) with the knight's on-screen position and produces the 50x64 sprite ROM address, the walk-animation frame select, and a pixel-valid flag. It also runs the walk animation and mirrors the address horizontally when the knight faces left. It sits directly upstream of the per-frame sprite ROM/palette stages and the colour mux.

## Interface
Parameters:
- FRAMES_PER_STEP, 6: video frames each walk frame is held.
- NUM_WALK_FRAMES, 4: walk-cycle length; frame_sel 1..NUM_WALK_FRAMES; 0 = idle pose.

Ports:
- vga_clk  in  1  pixel clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- DrawX  in  10  beam column, 0..799.
- DrawY  in  10  beam row, 0..524.
- pos_x  in  10  knight top-left column, from game logic.
- pos_y  in  10  knight top-left row.
- facing_left  in  1  1 = mirror sprite horizontally.
- walking  in  1  1 = knight moving horizontally.
- rom_address  out  12  address into the selected 50x64 ROM.
- frame_sel  out  3  ROM/frame select for the downstream mux.
- sprite_on  out  1  pixel lies inside the sprite box; aligned with the palette colour register.

## Operation
- **Start of frame (sof).** One-cycle internal pulse on the first cycle with DrawX==0 && DrawY==0 after any cycle where that is false.
- **Latching at sof.** pos_x, pos_y and facing_left are latched on sof and used for the whole frame, so there is no tearing. walking is sampled only on sof.
- **Animation FSM.** States IDLE and WALK.
  - IDLE: frame_sel_int=0. On sof with walking=1: go to WALK, frame_sel_int=1, step_cnt=0.
  - WALK, on sof with walking=0: go to IDLE, frame_sel_int=0, step_cnt=0.
  - WALK, on sof with walking=1: step_cnt++. When step_cnt reaches FRAMES_PER_STEP-1, step_cnt=0 and frame_sel_int advances; NUM_WALK_FRAMES wraps to 1.
  - Outside sof the FSM holds.
- **Hit test.** dx = DrawX - pos_x_l and dy = DrawY - pos_y_l, both 11-bit two's complement. Hit when 0<=dx<50 and 0<=dy<64. Negative results never hit, so sprites clip correctly at the left and top edges.
- **Address.** xm = facing_left_l ? 49-dx : dx. rom_address = dy*50 + xm (max 3199).
  - Compute dy*50 as (dy<<5)+(dy<<4)+(dy<<1). No divider or multiplier.
  - When not hit, rom_address=0.
- **Reset values.** rom_address=0, frame_sel=0, sprite_on=0, state=IDLE, step_cnt=0, latched position=0, facing=0.

## Timing
- **Stage 1 (posedge N+1).** rom_address and frame_sel register from the DrawX/DrawY sampled at edge N. The downstream ROM reads on the following negedge.
- **Stage 2 (posedge N+2).** sprite_on registers, aligned with the downstream colour register.
- **frame_sel stability.**
  - frame_sel updates only at sof. The first pixel of a frame already uses the new frame_sel.
  - frame_sel is registered alongside rom_address, so address and frame never mismatch within a pixel.
- **Reset mid-frame.** Outputs clear immediately and asynchronously. Animation resumes from IDLE at the next sof.
- **walking toggling between sofs.** Ignored until the next sof.
- **facing_left change mid-frame.** Takes effect at the next frame only.

## Structure
- **Package knight_pkg.** Constants SPRITE_W=50, SPRITE_H=64, ADDR_W=12; enum anim_state_t {IDLE, WALK}. Shared with the ROM example and colour-mux blocks.
- **Sub-module knight_anim_fsm.** Inputs: sof, walking. Output: frame_sel_int. Contains the step counter and FSM.
- **Top.** Holds sof detection, the latches, the hit test, address arithmetic and the pipeline.

## Test plan
- **Reset.** Assert reset_n=0 mid-line -> all outputs 0 within the same cycle; after release with walking=0 for 3 frames, frame_sel stays 0.
- **Address corners.** pos=(100,200), facing_left=0, DrawX=100/DrawY=200 -> rom_address=0 and sprite_on=1 two cycles later; DrawX=149/DrawY=263 -> 3199; DrawX=150 -> sprite_on=0.
- **Mirroring.** Same position, facing_left=1: DrawX=100/DrawY=200 -> 49; DrawX=149/DrawY=201 -> 50.
- **Walk cycle.** Hold walking=1 over 25 frames, FRAMES_PER_STEP=6 -> frame_sel sequence 1(x6), 2(x6), 3(x6), 4(x6), 1. walking=0 at next sof -> 0.
- **Clipping.** pos_x=780, DrawX=5 -> sprite_on=0. pos_x=0, pos_y=0, DrawX=0, DrawY=0 -> address 0, hit.
- **Mid-frame input changes.** Change pos_x, facing_left and walking at DrawY=240 -> no output change until the next sof.
